// File: rtl/ram_fifo_ctrl_if.sv
// Streaming push/pop handshakes plus the two RAM port connections of ram_fifo_ctrl.
// Valid/ready rule for both streams: a word moves on a rising edge where valid && ready;
// valid never waits on ready, and data is stable while valid is high and ready is low.
interface ram_fifo_ctrl_if #(
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic            s_valid;
  logic            s_ready;
  logic [DWID-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DWID-1:0] m_data;
  logic            wr_we;
  logic [DWID-1:0] wr_din;
  logic [AWID-1:0] wr_addr;
  logic [AWID-1:0] rd_addr;
  logic [DWID-1:0] rd_dout;
  logic [AWID+1:0] level;

  modport slave (
    input  s_valid, s_data, m_ready, rd_dout,
    output s_ready, m_valid, m_data, wr_we, wr_din, wr_addr, rd_addr, level
  );

  modport master (
    output s_valid, s_data, m_ready, rd_dout,
    input  s_ready, m_valid, m_data, wr_we, wr_din, wr_addr, rd_addr, level
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a two-port RAM with a registered read port; a 2-entry
// output buffer hides the read latency so the pop side streams one word per cycle.
module ram_fifo_ctrl #(
  parameter int DEPTH = 256,
  parameter int AWID  = 8,
  parameter int DWID  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  ram_fifo_ctrl_if.slave     bus
);
  localparam logic [AWID:0] DEPTH_L = (AWID+1)'(DEPTH);

  logic [AWID:0]   wr_ptr_q, wr_ptr_d;
  logic [AWID:0]   rd_ptr_q, rd_ptr_d;
  logic            rd_pend_q, rd_pend_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  logic [DWID-1:0] buf0_q, buf0_d;
  logic [DWID-1:0] buf1_q, buf1_d;

  logic [AWID:0]   ram_used;
  logic            push_ok;
  logic            push;
  logic            pop;
  logic [2:0]      occ;
  logic            rd_go;

  assign ram_used = wr_ptr_q - rd_ptr_q;
  // s_ready is held low during reset, not just after it, hence the rst_n term.
  assign push_ok  = rst_n & ~clear & (ram_used != DEPTH_L);
  assign push     = bus.s_valid & push_ok;
  assign pop      = (buf_cnt_q != 2'd0) & bus.m_ready & ~clear;
  // Buffer slots that will be committed after this edge; a read may issue only
  // if its returning word is guaranteed a free slot.
  assign occ      = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_go    = (ram_used != '0) & (occ < 3'd2) & ~clear;

  assign bus.s_ready = push_ok;
  assign bus.wr_we   = push;
  assign bus.wr_din  = bus.s_data;
  assign bus.wr_addr = wr_ptr_q[AWID-1:0];
  assign bus.rd_addr = rd_ptr_q[AWID-1:0];
  assign bus.m_valid = (buf_cnt_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign bus.level   = {1'b0, ram_used} + (AWID+2)'(rd_pend_q) + (AWID+2)'(buf_cnt_q);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_pend_d = rd_go;
    buf_cnt_d = buf_cnt_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
    // Shift the buffer on pop first, then land the returning word in the first free slot.
    if (pop) buf0_d = buf1_q;
    if (rd_pend_q) begin
      if (occ == 3'd1) buf0_d = bus.rd_dout;
      else             buf1_d = bus.rd_dout;
    end
    buf_cnt_d = occ[1:0];
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_pend_d = 1'b0;
      buf_cnt_d = 2'd0;
      buf0_d    = '0;
      buf1_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
      buf_cnt_q <= buf_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Controller that turns a two-port RAM (DEPTH x DWID, one registered read port, one write port) into a streaming FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the dual-port RAM.
- Drives the write-side signals we/din/addr on one RAM port and addr on the other port (that port's we is tied 0).
- Consumes that port's registered dout.
- Hides the RAM's 1-cycle read latency with a 2-entry output buffer, so the pop side sustains 1 word/cycle.

Parameters:
DEPTH, 256, RAM words; power of two
AWID, 8, RAM address width; log2(DEPTH)
DWID, 16, data width

Ports:
clk  in  1  single clock for all logic and both RAM ports
rst_n  in  1  reset, asynchronous assert, active-low
clear  in  1  synchronous flush, active-high
s_valid  in  1  push request
s_ready  out  1  push accepted when s_valid&s_ready
s_data  in  DWID  push data
m_valid  out  1  pop data available
m_ready  in  1  pop taken when m_valid&m_ready
m_data  out  DWID  head-of-FIFO data
wr_we  out  1  RAM write port we
wr_din  out  DWID  RAM write port din
wr_addr  out  AWID  RAM write port addr
rd_addr  out  AWID  RAM read port addr (port we tied 0 externally)
rd_dout  in  DWID  RAM read port dout, valid the cycle after rd_addr is sampled
level  out  AWID+2  total words held (RAM + in-flight + buffer)

Behaviour:
- Reset (rst_n=0, async):
  - wr_ptr=0, rd_ptr=0, rd_pend=0, buffer empty.
  - s_ready=0 while rst_n=0; s_ready=1 from the first cycle after release.
  - m_valid=0, m_data=0, wr_we=0, level=0.
- Pointers wr_ptr, rd_ptr are AWID+1 bits; the RAM address is the low AWID bits, so pointers wrap at DEPTH.
- ram_used = wr_ptr - rd_ptr, modulo 2^(AWID+1).
- Push:
  - s_ready = (ram_used != DEPTH) & !clear.
  - On accept: wr_we=1, wr_addr=wr_ptr[AWID-1:0], wr_din=s_data (all combinational); wr_ptr++ at the edge.
- Read issue, combinational:
  - rd_go = (ram_used != 0) & (buf_cnt + rd_pend - pop < 2) & !clear.
  - rd_addr = rd_ptr[AWID-1:0] at all times.
  - When rd_go: rd_ptr++ and rd_pend<=1 at the edge; otherwise rd_pend<=0.
- Output buffer:
  - 2-entry FIFO of registers; head drives m_data; m_valid = (buf_cnt != 0).
  - When rd_pend=1, rd_dout is written into the buffer that edge.
  - Capture and pop in the same cycle are both honoured.
  - Overflow cannot occur: the rd_go rule guarantees it; a bench assertion checks this.
- Read/write collision: impossible. A read requires ram_used > 0 and a write requires ram_used < DEPTH, so the addresses always differ.
- Latency, empty FIFO:
  - Push accepted at edge E0 → read issued in the cycle after E0 → captured at E2 → m_valid=1 after E2.
  - Sustained throughput: 1 push and 1 pop per cycle, with no bubbles once m_valid is up.
- Capacity: DEPTH+2 words. s_ready drops only when the RAM holds DEPTH words.
- level: ram_used + rd_pend + buf_cnt, registered-state derived (combinational from registers).
- Simultaneous push and pop: level is unchanged.
- At full, a pop frees buffer space → rd_go → ram_used decrements → s_ready returns one cycle later.
- clear=1 at an edge:
  - Pointers, rd_pend and buffer reset to empty; any in-flight rd_dout is discarded.
  - No push or pop is accepted in that cycle.
- Reset mid-operation: all state returns to reset values immediately; RAM contents are don't-care.

Test Plan:
- Reset, then push 0x1234 on an empty FIFO at E0 (m_ready=0) → wr_we=1, wr_addr=0 in that cycle; m_valid=1 and m_data=0x1234 after E2; level=1.
- Stream 300 words 0..299 with s_valid=1 and m_ready=1 throughout → output is 0..299 in order; after the pipeline fills, one word per cycle with no m_valid gaps; level ≤ 3.
- Push with m_ready=0 until s_ready=0 → exactly DEPTH+2=258 accepts; level=258; wr_addr wraps 255→0 once. Then pop 258 → data in order, m_valid=0 afterwards, level=0.
- At full, one pop → s_ready=1 within 2 cycles; one push accepted; level returns to 258.
- Assert clear for 1 cycle while a read is pending and 2 words are buffered → next cycle m_valid=0, level=0; a subsequent push of 0xBEEF pops as 0xBEEF, with no stale data.
- Drop rst_n asynchronously mid-stream between clock edges → m_valid, s_ready, wr_we go 0 immediately; after release s_ready=1 and level=0.
